// File: rtl/ps2_host_tx_pkg.sv
// Shared types and constants for the PS/2 host-to-device transmit path.
// The line filter in this package's family is also used by the receive path.
package ps2_host_tx_pkg;

  typedef enum logic [2:0] {
    IDLE,
    INHIBIT,
    START,
    BITS,
    ACK,
    WAIT_IDLE
  } ps2tx_state_t;

  localparam int unsigned PS2TX_START_HOLD = 16;
  localparam int unsigned PS2TX_FRAME_BITS = 10;

  // Wire order, LSB first: data[7:0], odd parity, stop.
  function automatic logic [PS2TX_FRAME_BITS-1:0] ps2tx_frame(input logic [7:0] data);
    return {1'b1, ~^data, data};
  endfunction

endpackage

// File: rtl/ps2_line_filter.sv
// Two-flop synchroniser plus stability filter for one PS/2 pad, with a
// one-cycle strobe on each filtered high-to-low transition.
module ps2_line_filter #(
  parameter int unsigned FILTER_LEN = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic line_in,
  output logic line_f,
  output logic fall
);

  localparam int unsigned CNT_W = $clog2(FILTER_LEN) + 1;

  logic [1:0]       sync_q;
  logic             filt_q, filt_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             fall_q, fall_d;

  // A new level is taken only after FILTER_LEN consecutive cycles of disagreement.
  always_comb begin
    filt_d = filt_q;
    cnt_d  = '0;
    if (sync_q[1] != filt_q) begin
      if (cnt_q == CNT_W'(FILTER_LEN - 1)) begin
        filt_d = sync_q[1];
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
    fall_d = filt_q & ~filt_d;
  end

  // NOTE: state flops use non-blocking assignments so every flop samples the
  // pre-edge values; reset lands on the idle-high bus level so no false edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= 2'b11;
      filt_q <= 1'b1;
      cnt_q  <= '0;
      fall_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[0], line_in};
      filt_q <= filt_d;
      cnt_q  <= cnt_d;
      fall_q <= fall_d;
    end
  end

  assign line_f = filt_q;
  assign fall   = fall_q;

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device byte transmitter driving open-drain clock/data enables.
// The pad wrapper ties each pad to 0 when its enable is set, 'z otherwise.
module ps2_host_tx
  import ps2_host_tx_pkg::*;
#(
  parameter int unsigned CLK_FREQ      = 28_000_000,
  parameter int unsigned INHIBIT_US    = 120,
  parameter int unsigned FIRST_EDGE_US = 15000,
  parameter int unsigned BIT_US        = 2000,
  parameter int unsigned FILTER_LEN    = 8
) (
  input  logic       clk28,
  input  logic       rst,
  input  logic       ps2_clk_in,
  input  logic       ps2_dat_in,
  output logic       ps2_clk_oe,
  output logic       ps2_dat_oe,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       tx_done,
  output logic       tx_error,
  output logic       busy
);

  localparam int unsigned CYC_PER_US  = CLK_FREQ / 1_000_000;
  localparam int unsigned INHIBIT_CYC = CYC_PER_US * INHIBIT_US;
  localparam int unsigned FIRST_CYC   = CYC_PER_US * FIRST_EDGE_US;
  localparam int unsigned BIT_CYC     = CYC_PER_US * BIT_US;
  localparam int unsigned TMR_SPAN    = (FIRST_CYC > INHIBIT_CYC) ? FIRST_CYC : INHIBIT_CYC;
  localparam int unsigned TMR_W       = $clog2(TMR_SPAN) + 1;

  localparam logic [TMR_W-1:0] TMR_INHIBIT = TMR_W'(INHIBIT_CYC - 1);
  localparam logic [TMR_W-1:0] TMR_START   = TMR_W'(PS2TX_START_HOLD - 1);
  localparam logic [TMR_W-1:0] TMR_FIRST   = TMR_W'(FIRST_CYC - 1);
  localparam logic [TMR_W-1:0] TMR_BIT     = TMR_W'(BIT_CYC - 1);
  localparam logic [3:0]       LAST_IDX    = 4'(PS2TX_FRAME_BITS - 1);

  logic clk_f, clk_fall, dat_f, dat_fall_unused;

  ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_clk_filter (
    .clk     (clk28),
    .rst     (rst),
    .line_in (ps2_clk_in),
    .line_f  (clk_f),
    .fall    (clk_fall)
  );

  ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_dat_filter (
    .clk     (clk28),
    .rst     (rst),
    .line_in (ps2_dat_in),
    .line_f  (dat_f),
    .fall    (dat_fall_unused)
  );

  ps2tx_state_t                  state_q, state_d;
  logic [TMR_W-1:0]              tmr_q, tmr_d;
  logic [3:0]                    idx_q, idx_d;
  logic [PS2TX_FRAME_BITS-1:0]   shift_q, shift_d;
  logic                          clk_oe_q, clk_oe_d;
  logic                          dat_oe_q, dat_oe_d;
  logic                          done_q, done_d;
  logic                          err_q, err_d;
  logic                          timeout;
  logic                          tmr_zero;

  assign tmr_zero = (tmr_q == '0);

  // NOTE: every output of this block gets a default first, so no path can
  // leave a variable unassigned and infer a latch.
  always_comb begin
    state_d  = state_q;
    tmr_d    = tmr_q - 1'b1;
    idx_d    = idx_q;
    shift_d  = shift_q;
    clk_oe_d = clk_oe_q;
    dat_oe_d = dat_oe_q;
    done_d   = 1'b0;
    err_d    = 1'b0;
    timeout  = 1'b0;

    case (state_q)
      IDLE: begin
        tmr_d    = '0;
        clk_oe_d = 1'b0;
        dat_oe_d = 1'b0;
        if (tx_valid) begin
          shift_d  = ps2tx_frame(tx_data);
          idx_d    = '0;
          tmr_d    = TMR_INHIBIT;
          clk_oe_d = 1'b1;
          state_d  = INHIBIT;
        end
      end
      // Device edges during INHIBIT/START are ignored: the host request wins.
      INHIBIT: begin
        if (tmr_zero) begin
          dat_oe_d = 1'b1;
          tmr_d    = TMR_START;
          state_d  = START;
        end
      end
      START: begin
        if (tmr_zero) begin
          clk_oe_d = 1'b0;
          tmr_d    = TMR_FIRST;
          state_d  = BITS;
        end
      end
      BITS: begin
        if (clk_fall) begin
          dat_oe_d = ~shift_q[idx_q];
          idx_d    = idx_q + 1'b1;
          tmr_d    = TMR_BIT;
          if (idx_q == LAST_IDX) begin
            state_d = ACK;
          end
        end else if (tmr_zero) begin
          timeout = 1'b1;
        end
      end
      ACK: begin
        if (clk_fall) begin
          if (dat_f) begin
            err_d   = 1'b1;
            state_d = IDLE;
          end else begin
            tmr_d   = TMR_BIT;
            state_d = WAIT_IDLE;
          end
        end else if (tmr_zero) begin
          timeout = 1'b1;
        end
      end
      WAIT_IDLE: begin
        if (clk_f && dat_f) begin
          done_d  = 1'b1;
          state_d = IDLE;
        end else if (tmr_zero) begin
          timeout = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    if (timeout) begin
      state_d  = IDLE;
      clk_oe_d = 1'b0;
      dat_oe_d = 1'b0;
      err_d    = 1'b1;
    end
  end

  always_ff @(posedge clk28 or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      tmr_q    <= '0;
      idx_q    <= '0;
      shift_q  <= '0;
      clk_oe_q <= 1'b0;
      dat_oe_q <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      tmr_q    <= tmr_d;
      idx_q    <= idx_d;
      shift_q  <= shift_d;
      clk_oe_q <= clk_oe_d;
      dat_oe_q <= dat_oe_d;
      done_q   <= done_d;
      err_q    <= err_d;
    end
  end

  // busy also tells the receive path to ignore the bus during a host frame.
  assign ps2_clk_oe = clk_oe_q;
  assign ps2_dat_oe = dat_oe_q;
  assign tx_ready   = (state_q == IDLE);
  assign busy       = (state_q != IDLE);
  assign tx_done    = done_q;
  assign tx_error   = err_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Self-checking bench for ps2_host_tx: a device BFM on open-drain pads and a
// byte-level reference model of the PS/2 host-to-device frame.
module tb_ps2_host_tx;

  localparam int unsigned CLK_FREQ      = 28_000_000;
  localparam int unsigned INHIBIT_US    = 120;
  localparam int unsigned FIRST_EDGE_US = 100;
  localparam int unsigned BIT_US        = 20;
  localparam int unsigned FILTER_LEN    = 8;

  localparam int INHIBIT_CYC = 3360;
  localparam int START_HOLD  = 16;
  localparam int FIRST_CYC   = 2800;

  // Device clock is faster than a real keyboard to keep the run short.
  localparam int HALF      = 60;
  localparam int START_DLY = 100;
  localparam int ACK_LEAD  = 20;

  localparam int M_ACK   = 0;
  localparam int M_NACK  = 1;
  localparam int M_NOCLK = 2;
  localparam int M_STALL = 3;

  localparam logic [5:0] V_IDLE = 6'b001000;
  localparam logic [5:0] V_DONE = 6'b001100;
  localparam logic [5:0] V_ERR  = 6'b001010;

  logic       clk28 = 1'b0;
  logic       rst = 1'b1;
  logic       dev_clk_low = 1'b0;
  logic       dev_dat_low = 1'b0;
  logic       glitch_low = 1'b0;
  logic       ps2_clk_in, ps2_dat_in;
  logic       ps2_clk_oe, ps2_dat_oe;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0;
  logic       tx_ready, tx_done, tx_error, busy;

  int checks = 0;
  int failures = 0;

  int         inh_cnt, start_cnt, done_cnt, err_cnt, both_cnt;
  logic       mon_clear = 1'b0;
  logic       bfm_abort = 1'b0;
  int         bfm_edge;
  logic [9:0] bfm_seen;
  int         bfm_nseen;
  int         frame_lat;
  logic [5:0] at_end;

  always #5 clk28 = ~clk28;

  assign ps2_clk_in = ~(ps2_clk_oe | dev_clk_low | glitch_low);
  assign ps2_dat_in = ~(ps2_dat_oe | dev_dat_low);

  ps2_host_tx #(
    .CLK_FREQ      (CLK_FREQ),
    .INHIBIT_US    (INHIBIT_US),
    .FIRST_EDGE_US (FIRST_EDGE_US),
    .BIT_US        (BIT_US),
    .FILTER_LEN    (FILTER_LEN)
  ) dut (
    .clk28      (clk28),
    .rst        (rst),
    .ps2_clk_in (ps2_clk_in),
    .ps2_dat_in (ps2_dat_in),
    .ps2_clk_oe (ps2_clk_oe),
    .ps2_dat_oe (ps2_dat_oe),
    .tx_data    (tx_data),
    .tx_valid   (tx_valid),
    .tx_ready   (tx_ready),
    .tx_done    (tx_done),
    .tx_error   (tx_error),
    .busy       (busy)
  );

  always @(negedge clk28) begin
    if (mon_clear) begin
      inh_cnt   <= 0;
      start_cnt <= 0;
      done_cnt  <= 0;
      err_cnt   <= 0;
      both_cnt  <= 0;
    end else begin
      if (ps2_clk_oe && !ps2_dat_oe) inh_cnt <= inh_cnt + 1;
      if (ps2_clk_oe && ps2_dat_oe) start_cnt <= start_cnt + 1;
      if (tx_done) done_cnt <= done_cnt + 1;
      if (tx_error) err_cnt <= err_cnt + 1;
      if (tx_done && tx_error) both_cnt <= both_cnt + 1;
    end
  end

  function automatic logic [9:0] exp_frame(input logic [7:0] b);
    logic par;
    par = ($countones(b) % 2 == 0);
    return {1'b1, par, b};
  endfunction

  function automatic logic [5:0] out_vec();
    return {ps2_clk_oe, ps2_dat_oe, tx_ready, tx_done, tx_error, busy};
  endfunction

  // Device side: waits for request-to-send, clocks the frame, samples on rise.
  task automatic device_rx(input int mode, input int glitch_edge);
    int t;
    bfm_seen  = '0;
    bfm_nseen = 0;
    bfm_edge  = 0;
    if (mode == M_NOCLK) return;
    t = 0;
    while (!(ps2_clk_in && !ps2_dat_in) && t < 20000 && !bfm_abort) begin
      @(negedge clk28);
      t++;
    end
    if (t >= 20000 || bfm_abort) return;
    repeat (START_DLY) @(negedge clk28);
    for (int k = 1; k <= 11; k++) begin
      if (bfm_abort || (mode == M_STALL && k == 6)) break;
      if (k == 11 && mode == M_ACK) begin
        dev_dat_low = 1'b1;
        repeat (ACK_LEAD) @(negedge clk28);
      end
      dev_clk_low = 1'b1;
      bfm_edge    = k;
      repeat (HALF) @(negedge clk28);
      dev_clk_low = 1'b0;
      if (k <= 10) begin
        bfm_seen[k-1] = ps2_dat_in;
        bfm_nseen++;
      end
      if (k == glitch_edge) begin
        repeat (20) @(negedge clk28);
        glitch_low = 1'b1;
        repeat (3) @(negedge clk28);
        glitch_low = 1'b0;
        repeat (HALF - 23) @(negedge clk28);
      end else begin
        repeat (HALF) @(negedge clk28);
      end
    end
    repeat (ACK_LEAD) @(negedge clk28);
    dev_clk_low = 1'b0;
    dev_dat_low = 1'b0;
  endtask

  task automatic start_request(input logic [7:0] b);
    mon_clear = 1'b1;
    @(negedge clk28);
    #1 mon_clear = 1'b0;
    tx_data  = b;
    tx_valid = 1'b1;
    @(posedge clk28);
    #1 tx_valid = 1'b0;
    tx_data = 8'($urandom);
  endtask

  task automatic run_frame(input logic [7:0] b, input int mode, input int glitch_edge,
                           input bit mid_valid);
    start_request(b);
    frame_lat = -1;
    fork
      device_rx(mode, glitch_edge);
      begin : wait_end
        int n;
        n = 0;
        while (!(tx_done || tx_error) && n < 30000) begin
          @(posedge clk28);
          n++;
          #1;
        end
        frame_lat = (tx_done || tx_error) ? n : -1;
        at_end = out_vec();
      end
      if (mid_valid) begin
        repeat (1000) @(negedge clk28);
        tx_data = 8'h55; tx_valid = 1'b1;
        @(negedge clk28);
        tx_valid = 1'b0;
        repeat (2800) @(negedge clk28);
        tx_data = 8'h55; tx_valid = 1'b1;
        @(negedge clk28);
        tx_valid = 1'b0;
      end
    join
    repeat (30) @(negedge clk28);
  endtask

  task automatic test_frame(input logic [7:0] b, input string name);
    logic [9:0] exp;
    exp = exp_frame(b);
    run_frame(b, M_ACK, 0, 1'b0);
    checks++;
    if (bfm_seen !== exp || bfm_nseen != 10) begin
      failures++;
      $display("FAIL %s wire bits: got %b (%0d bits) expected %b (10 bits)", name, bfm_seen, bfm_nseen, exp);
    end
    checks++;
    if (done_cnt != 1 || err_cnt != 0 || both_cnt != 0) begin
      failures++;
      $display("FAIL %s pulses: done=%0d err=%0d both=%0d expected done=1 err=0 both=0", name, done_cnt, err_cnt, both_cnt);
    end
    checks++;
    if (at_end !== V_DONE) begin
      failures++;
      $display("FAIL %s outputs at done: got %b expected %b", name, at_end, V_DONE);
    end
    checks++;
    if (inh_cnt != INHIBIT_CYC || start_cnt != START_HOLD) begin
      failures++;
      $display("FAIL %s inhibit/start: got %0d/%0d expected %0d/%0d", name, inh_cnt, start_cnt, INHIBIT_CYC, START_HOLD);
    end
    checks++;
    if (out_vec() !== V_IDLE) begin
      failures++;
      $display("FAIL %s idle after frame: got %b expected %b", name, out_vec(), V_IDLE);
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk28);
    checks++;
    if (out_vec() !== V_IDLE) begin
      failures++;
      $display("FAIL reset outputs: got %b expected %b", out_vec(), V_IDLE);
    end
    rst = 1'b0;
    repeat (20) @(negedge clk28);
  endtask

  task automatic test_led_cmd();
    test_frame(8'hED, "led_cmd");
    checks++;
    if (bfm_seen !== 10'b11_1110_1101) begin
      failures++;
      $display("FAIL led_cmd literal: got %b expected %b", bfm_seen, 10'b11_1110_1101);
    end
  endtask

  task automatic test_parity();
    test_frame(8'h07, "parity_07");
    checks++;
    if (bfm_seen[8] !== 1'b0) begin
      failures++;
      $display("FAIL parity_07 bit: got %b expected 0", bfm_seen[8]);
    end
    test_frame(8'h00, "parity_00");
    checks++;
    if (bfm_seen[8] !== 1'b1) begin
      failures++;
      $display("FAIL parity_00 bit: got %b expected 1", bfm_seen[8]);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 3; i++) test_frame(8'($urandom), "random");
  endtask

  task automatic test_first_edge_timeout();
    run_frame(8'h5A, M_NOCLK, 0, 1'b0);
    checks++;
    if (frame_lat != INHIBIT_CYC + START_HOLD + FIRST_CYC) begin
      failures++;
      $display("FAIL first_edge latency: got %0d expected %0d", frame_lat, INHIBIT_CYC + START_HOLD + FIRST_CYC);
    end
    checks++;
    if (at_end !== V_ERR) begin
      failures++;
      $display("FAIL first_edge outputs at error: got %b expected %b", at_end, V_ERR);
    end
    checks++;
    if (err_cnt != 1 || done_cnt != 0) begin
      failures++;
      $display("FAIL first_edge pulses: err=%0d done=%0d expected 1/0", err_cnt, done_cnt);
    end
  endtask

  task automatic test_nack();
    run_frame(8'hF3, M_NACK, 0, 1'b0);
    checks++;
    if (err_cnt != 1 || done_cnt != 0 || at_end !== V_ERR) begin
      failures++;
      $display("FAIL nack: err=%0d done=%0d outputs=%b expected 1/0/%b", err_cnt, done_cnt, at_end, V_ERR);
    end
    checks++;
    if (bfm_seen !== exp_frame(8'hF3)) begin
      failures++;
      $display("FAIL nack wire bits: got %b expected %b", bfm_seen, exp_frame(8'hF3));
    end
    test_frame(8'hFF, "after_nack");
  endtask

  task automatic test_bit_timeout();
    run_frame(8'h3C, M_STALL, 0, 1'b0);
    checks++;
    if (err_cnt != 1 || done_cnt != 0 || at_end !== V_ERR || bfm_nseen != 5) begin
      failures++;
      $display("FAIL bit_timeout: err=%0d done=%0d outputs=%b bits=%0d expected 1/0/%b/5", err_cnt, done_cnt, at_end, V_ERR, bfm_nseen);
    end
  endtask

  task automatic test_reset_mid_frame();
    start_request(8'hA5);
    fork
      device_rx(M_ACK, 0);
      begin : reset_hit
        int n;
        n = 0;
        while (bfm_edge < 4 && n < 20000) begin
          @(negedge clk28);
          n++;
        end
        checks++;
        if (bfm_edge < 4) begin
          failures++;
          $display("FAIL reset_mid wait for bit 4: got edge %0d expected 4", bfm_edge);
        end
        @(negedge clk28);
        #2 rst = 1'b1;
        #1;
        checks++;
        if (out_vec() !== V_IDLE) begin
          failures++;
          $display("FAIL reset_mid outputs: got %b expected %b", out_vec(), V_IDLE);
        end
        bfm_abort = 1'b1;
        repeat (3) @(negedge clk28);
        rst = 1'b0;
      end
    join
    bfm_abort = 1'b0;
    repeat (50) @(negedge clk28);
    checks++;
    if (done_cnt != 0 || err_cnt != 0) begin
      failures++;
      $display("FAIL reset_mid pulses: done=%0d err=%0d expected 0/0", done_cnt, err_cnt);
    end
    test_frame(8'h96, "after_reset");
  endtask

  task automatic test_mid_valid();
    run_frame(8'hC3, M_ACK, 0, 1'b1);
    checks++;
    if (bfm_seen !== exp_frame(8'hC3) || done_cnt != 1) begin
      failures++;
      $display("FAIL mid_valid frame: got %b done=%0d expected %b done=1", bfm_seen, done_cnt, exp_frame(8'hC3));
    end
    repeat (200) @(negedge clk28);
    checks++;
    if (inh_cnt != INHIBIT_CYC || out_vec() !== V_IDLE) begin
      failures++;
      $display("FAIL mid_valid no restart: inhibit=%0d outputs=%b expected %0d %b", inh_cnt, out_vec(), INHIBIT_CYC, V_IDLE);
    end
  endtask

  task automatic test_glitch();
    logic [7:0] b;
    int         g;
    b = 8'($urandom);
    g = int'($urandom_range(2, 9));
    run_frame(b, M_ACK, g, 1'b0);
    checks++;
    if (bfm_seen !== exp_frame(b) || done_cnt != 1 || err_cnt != 0) begin
      failures++;
      $display("FAIL glitch at edge %0d: got %b done=%0d err=%0d expected %b done=1 err=0", g, bfm_seen, done_cnt, err_cnt, exp_frame(b));
    end
  endtask

  initial begin
    test_reset();
    test_led_cmd();
    test_parity();
    test_random();
    test_first_edge_timeout();
    test_nack();
    test_bit_timeout();
    test_reset_mid_frame();
    test_mid_valid();
    test_glitch();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
